// File: rtl/alu_mc_pkg.sv
// Shared ALU opcode space and FSM state encoding for the multi-cycle ALU.
// New opcodes are only ever appended so existing encodings never move.
package alu_mc_pkg;

  localparam int AC_N = 4;

  localparam logic [AC_N-1:0] AC_ADX = 4'd0;
  localparam logic [AC_N-1:0] AC_SBX = 4'd1;
  localparam logic [AC_N-1:0] AC_AD  = 4'd2;
  localparam logic [AC_N-1:0] AC_SB  = 4'd3;
  localparam logic [AC_N-1:0] AC_AN  = 4'd4;
  localparam logic [AC_N-1:0] AC_OR  = 4'd5;
  localparam logic [AC_N-1:0] AC_XR  = 4'd6;
  localparam logic [AC_N-1:0] AC_LS  = 4'd7;
  localparam logic [AC_N-1:0] AC_SHL = 4'd8;
  localparam logic [AC_N-1:0] AC_SHR = 4'd9;
  localparam logic [AC_N-1:0] AC_MUL = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_SHF,
    ST_DONE
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: add/sub variants, bitwise logic and unsigned
// less-than. Multi-cycle and undefined opcodes yield S=0, carry=0.
module alu_core #(
  parameter int WIDTH = 8,
  parameter int AC_N  = alu_mc_pkg::AC_N
) (
  input  logic [AC_N-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o
);
  import alu_mc_pkg::*;

  logic [WIDTH:0] sum;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    sum    = '0;
    s_o    = '0;
    cout_o = 1'b0;
    case (op_i)
      AC_ADX: sum = {1'b0, a_i} + {1'b0, b_i};
      AC_SBX: sum = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);
      AC_AD:  sum = {1'b0, a_i} + {1'b0, b_i} + (WIDTH+1)'(cin_i);
      AC_SB:  sum = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(cin_i);
      AC_AN:  s_o = a_i & b_i;
      AC_OR:  s_o = a_i | b_i;
      AC_XR:  s_o = a_i ^ b_i;
      AC_LS:  s_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      default: ;
    endcase
    // Carry out of the extended sum is the no-borrow flag for subtraction.
    if (op_i == AC_ADX || op_i == AC_SBX || op_i == AC_AD || op_i == AC_SB) begin
      s_o    = sum[WIDTH-1:0];
      cout_o = sum[WIDTH];
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: one-cycle ops via alu_core, serial shift-add multiply and
// one-bit-per-cycle shifts, with a valid/ready handshake on both sides.
module alu_mc #(
  parameter int WIDTH = 8,
  parameter int AC_N  = alu_mc_pkg::AC_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AC_N-1:0]  CS,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             zero,
  output logic             carry_out
);
  import alu_mc_pkg::*;

  localparam int LG    = $clog2(WIDTH);
  localparam int CNT_W = LG + 1;

  state_e              state_q, state_d;
  logic [AC_N-1:0]     op_q, op_d;
  logic [WIDTH-1:0]    sh_q, sh_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [2*WIDTH-1:0]  prod_q, prod_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    s_q, s_d;
  logic                cout_q, cout_d;

  logic [WIDTH-1:0]    core_s;
  logic                core_cout;
  logic [LG-1:0]       shamt;
  logic [WIDTH:0]      mul_sum;
  logic [2*WIDTH-1:0]  prod_step;
  logic                bit_out;

  alu_core #(.WIDTH(WIDTH), .AC_N(AC_N)) u_core (
    .op_i   (CS),
    .a_i    (data_a),
    .b_i    (data_b),
    .cin_i  (carry_in),
    .s_o    (core_s),
    .cout_o (core_cout)
  );

  assign shamt     = data_b[LG-1:0];
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign S         = s_q;
  assign zero      = (s_q == '0);
  assign carry_out = cout_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sh_d    = sh_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    bit_out = 1'b0;
    // Upper half accumulates the multiplicand when the current multiplier LSB is set.
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {mul_sum, prod_q[WIDTH-1:1]};

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d  = CS;
          cnt_d = '0;
          if (CS == AC_MUL) begin
            mcand_d = data_a;
            prod_d  = {{WIDTH{1'b0}}, data_b};
            state_d = ST_MUL;
          end else if (CS == AC_SHL || CS == AC_SHR) begin
            if (shamt == '0) begin
              s_d     = data_a;
              cout_d  = 1'b0;
              state_d = ST_DONE;
            end else begin
              sh_d    = data_a;
              cnt_d   = CNT_W'(shamt);
              state_d = ST_SHF;
            end
          end else begin
            s_d     = core_s;
            cout_d  = core_cout;
            state_d = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          s_d     = prod_step[WIDTH-1:0];
          cout_d  = |prod_step[2*WIDTH-1:WIDTH];
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_SHF: begin
        if (op_q == AC_SHL) begin
          sh_d    = {sh_q[WIDTH-2:0], 1'b0};
          bit_out = sh_q[WIDTH-1];
        end else begin
          sh_d    = {1'b0, sh_q[WIDTH-1:1]};
          bit_out = sh_q[0];
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          s_d     = sh_d;
          cout_d  = bit_out;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      sh_q    <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: vector table for each opcode plus hand-written
// sequences for DONE back-pressure, mid-operation reset and a 16-bit instance.
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_ready, carry_in, out_valid, out_ready, zero, carry_out;
  logic [3:0] CS;
  logic [7:0] data_a, data_b, S;

  logic        rst16, in_valid16, in_ready16, carry_in16, out_valid16, out_ready16, zero16, carry_out16;
  logic [3:0]  CS16;
  logic [15:0] data_a16, data_b16, S16;

  alu_mc #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .CS(CS),
    .data_a(data_a), .data_b(data_b), .carry_in(carry_in), .out_valid(out_valid),
    .out_ready(out_ready), .S(S), .zero(zero), .carry_out(carry_out)
  );

  alu_mc #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .in_valid(in_valid16), .in_ready(in_ready16), .CS(CS16),
    .data_a(data_a16), .data_b(data_b16), .carry_in(carry_in16), .out_valid(out_valid16),
    .out_ready(out_ready16), .S(S16), .zero(zero16), .carry_out(carry_out16)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    int         lat;
  } vec_t;

  vec_t vecs[20];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns cycles from accept until out_valid is first seen (1 = next cycle).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin);
    CS = op; data_a = a; data_b = b; carry_in = cin; in_valid = 1'b1;
    tick();
    // Scramble the operands after accept; the captured command must not change.
    in_valid = 1'b0; data_a = ~a; data_b = ~b; carry_in = ~cin; CS = AC_ADX;
  endtask

  initial begin
    int lat;
    int ov_seen;

    vecs[0]  = '{AC_ADX, 8'd212,  8'd44,  1'b0, 8'd0,    1'b1, 1};
    vecs[1]  = '{AC_AD,  8'd42,   8'd67,  1'b1, 8'd110,  1'b0, 1};
    vecs[2]  = '{AC_SBX, 8'd1,    8'd77,  1'b0, 8'd180,  1'b0, 1};
    vecs[3]  = '{AC_SB,  8'd9,    8'd64,  1'b1, 8'd201,  1'b0, 1};
    vecs[4]  = '{AC_LS,  8'd42,   8'd67,  1'b0, 8'd1,    1'b0, 1};
    vecs[5]  = '{AC_LS,  8'd67,   8'd42,  1'b0, 8'd0,    1'b0, 1};
    vecs[6]  = '{AC_AN,  8'd212,  8'd44,  1'b0, 8'd4,    1'b0, 1};
    vecs[7]  = '{AC_OR,  8'hA0,   8'h0A,  1'b0, 8'hAA,   1'b0, 1};
    vecs[8]  = '{AC_XR,  8'hFF,   8'h0F,  1'b0, 8'hF0,   1'b0, 1};
    vecs[9]  = '{AC_SBX, 8'd5,    8'd5,   1'b0, 8'd0,    1'b1, 1};
    vecs[10] = '{AC_MUL, 8'd13,   8'd21,  1'b0, 8'd17,   1'b1, 9};
    vecs[11] = '{AC_MUL, 8'd15,   8'd17,  1'b0, 8'd255,  1'b0, 9};
    vecs[12] = '{AC_SHL, 8'h81,   8'd1,   1'b0, 8'h02,   1'b1, 2};
    vecs[13] = '{AC_SHR, 8'h81,   8'd0,   1'b0, 8'h81,   1'b0, 1};
    vecs[14] = '{AC_SHR, 8'h81,   8'd3,   1'b0, 8'h10,   1'b0, 4};
    vecs[15] = '{AC_SHL, 8'h81,   8'd7,   1'b0, 8'h80,   1'b0, 8};
    vecs[16] = '{AC_SHL, 8'h40,   8'd2,   1'b0, 8'h00,   1'b1, 3};
    vecs[17] = '{AC_SHL, 8'h81,   8'd8,   1'b0, 8'h81,   1'b0, 1};
    vecs[18] = '{4'hF,   8'd3,    8'd3,   1'b1, 8'd0,    1'b0, 1};
    vecs[19] = '{AC_AD,  8'd255,  8'd0,   1'b1, 8'd0,    1'b1, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; CS = '0; data_a = '0; data_b = '0; carry_in = 1'b0;
    rst16 = 1'b1; in_valid16 = 1'b0; out_ready16 = 1'b0; CS16 = '0; data_a16 = '0; data_b16 = '0;
    carry_in16 = 1'b0;
    tick(); tick();
    rst = 1'b0; rst16 = 1'b0;

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_S", S, 0);
    check("rst_zero", zero, 1);
    check("rst_carry", carry_out, 0);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      if (vecs[i].lat > 1) check($sformatf("v%0d_busy_ready", i), in_ready, 0);
      wait_valid(lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_S", i), S, vecs[i].s);
      check($sformatf("v%0d_carry", i), carry_out, vecs[i].c);
      check($sformatf("v%0d_zero", i), zero, (vecs[i].s == 8'd0));
      check($sformatf("v%0d_done_ready", i), in_ready, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check($sformatf("v%0d_release", i), {out_valid, in_ready}, 2'b01);
    end

    // DONE back-pressure: result held, command pulses ignored, no extra result.
    issue(AC_ADX, 8'd100, 8'd50, 1'b0);
    wait_valid(lat);
    for (int k = 0; k < 3; k++) begin
      CS = AC_MUL; data_a = 8'd7; data_b = 8'd9; in_valid = (k != 1);
      tick();
      check($sformatf("hold%0d", k), {out_valid, in_ready, S, zero, carry_out},
            {1'b1, 1'b0, 8'd150, 1'b0, 1'b0});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    ov_seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid) ov_seen++;
    end
    check("hold_no_extra", ov_seen, 0);
    check("hold_S_kept", S, 150);

    // Reset in cycle 4 of MUL discards the operation.
    issue(AC_MUL, 8'd13, 8'd21, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mulrst_state", {in_ready, out_valid, S, zero, carry_out},
          {1'b1, 1'b0, 8'd0, 1'b1, 1'b0});
    ov_seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid) ov_seen++;
    end
    check("mulrst_no_result", ov_seen, 0);

    // Reset during SHF.
    issue(AC_SHL, 8'h01, 8'd6, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ov_seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid) ov_seen++;
    end
    check("shfrst_no_result", {ov_seen[7:0], in_ready}, {8'd0, 1'b1});

    // Reset in DONE wins over simultaneous in_valid and out_ready.
    issue(AC_ADX, 8'd1, 8'd1, 1'b0);
    check("pri_done", out_valid, 1);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; CS = AC_OR; data_a = 8'h5A; data_b = 8'h00;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("pri_rst", {in_ready, out_valid, S, zero}, {1'b1, 1'b0, 8'd0, 1'b1});
    tick();
    check("pri_no_accept", out_valid, 0);

    // 16-bit instance.
    CS16 = AC_ADX; data_a16 = 16'd40000; data_b16 = 16'd30000; in_valid16 = 1'b1;
    tick();
    in_valid16 = 1'b0; data_a16 = '0; data_b16 = '0;
    check("w16_valid", out_valid16, 1);
    check("w16_S", S16, 4464);
    check("w16_carry", {carry_out16, zero16}, 2'b10);
    out_ready16 = 1'b1;
    tick();
    out_ready16 = 1'b0;
    check("w16_release", in_ready16, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
